// File: rtl/conv_line_buffer.sv
// Vertical line buffer: emits a KERNEL_DIAMETER_N-tall pixel column per accepted input pixel.
// Latency: 1 cycle from input acceptance to tvalid_o through a single registered output stage.
// Backpressure: tready_o = !tvalid_o || tready_i; the output holds stable while stalled.
module conv_line_buffer #(
  parameter int PIXEL_W           = 8,
  parameter int KERNEL_DIAMETER_N = 5,
  parameter int MAX_LINE_W        = 1024,
  parameter     EXTEND_STRATEGY   = "ZERO_PAD",
  parameter     TARGET            = "FPGA"
) (
  input  logic                                 clk,
  input  logic                                 arst_n,
  input  logic                                 tvalid_i,
  input  logic [PIXEL_W-1:0]                   tdata_i,
  input  logic                                 tuser_i,
  input  logic                                 tlast_i,
  output logic                                 tready_o,
  output logic                                 tvalid_o,
  output logic [KERNEL_DIAMETER_N*PIXEL_W-1:0] tdata_o,
  output logic                                 tuser_o,
  output logic                                 tlast_o,
  input  logic                                 tready_i,
  output logic                                 err_o
);

  localparam int  K    = KERNEL_DIAMETER_N;
  localparam int  CW   = (MAX_LINE_W > 1) ? $clog2(MAX_LINE_W) : 1;
  localparam int  RW   = $clog2(K);
  localparam int  WW   = $clog2(MAX_LINE_W + 1);
  localparam bit  REPL = (EXTEND_STRATEGY == "REPLICATE");

  // Parameter legality is checked at elaboration; TARGET only selects how the stores map to memory.
  if (K < 3 || (K % 2) == 0) begin : g_bad_kernel
    $error("conv_line_buffer: KERNEL_DIAMETER_N must be odd and >= 3");
  end
  if (EXTEND_STRATEGY != "ZERO_PAD" && EXTEND_STRATEGY != "REPLICATE") begin : g_bad_extend
    $error("conv_line_buffer: EXTEND_STRATEGY must be ZERO_PAD or REPLICATE");
  end
  if (TARGET != "FPGA" && TARGET != "ASIC") begin : g_bad_target
    $error("conv_line_buffer: TARGET must be FPGA or ASIC");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        col, col_nxt, eff_col;
  logic [RW-1:0]        row, row_nxt, eff_row;
  logic [WW-1:0]        width, width_nxt, width_eff;
  logic                 err_nxt;
  logic                 accept, take, ovf_hit, len_bad;

  // Store i holds the line i+1 rows above the current one.
  logic [PIXEL_W-1:0]   mem [K-1][MAX_LINE_W];
  logic [PIXEL_W-1:0]   rd  [K-1];
  logic [PIXEL_W-1:0]   elem [K];
  logic [PIXEL_W-1:0]   top;
  logic [K*PIXEL_W-1:0] col_vec;

  assign tready_o = !tvalid_o || tready_i;
  assign accept   = tvalid_i && tready_o;
  // Only pixels inside a frame are processed; a tuser pixel always opens one.
  assign take     = accept && (state == ACTIVE || tuser_i);

  // A start-of-frame pixel is row 0 / column 0 with the width forgotten, whatever came before.
  assign eff_col   = tuser_i ? '0 : col;
  assign eff_row   = tuser_i ? '0 : row;
  assign width_eff = tuser_i ? '0 : width;

  // Last addressable column reached without end-of-line: the line is too long.
  assign ovf_hit = (eff_col == CW'(MAX_LINE_W - 1)) && !tlast_i;
  // width == 0 means not yet learned in this frame, so there is nothing to compare against.
  assign len_bad = tlast_i && (width_eff != '0) && ((WW'(eff_col) + WW'(1)) != width_eff);

  // Read every store at the current column and assemble the vertical column with edge extension.
  always_comb begin
    top = tdata_i;
    for (int i = 0; i < K - 1; i++) begin
      rd[i] = mem[i][eff_col];
    end
    for (int i = 1; i < K; i++) begin
      if (RW'(i) == eff_row) top = rd[i-1];
    end
    elem[0] = tdata_i;
    for (int i = 1; i < K; i++) begin
      if (RW'(i) <= eff_row) elem[i] = rd[i-1];
      else                   elem[i] = REPL ? top : '0;
    end
    col_vec = '0;
    for (int i = 0; i < K; i++) begin
      col_vec[i*PIXEL_W +: PIXEL_W] = elem[i];
    end
  end

  // Shift the column up one store (read-before-write); skipped while the line overflows.
  always_ff @(posedge clk) begin
    if (take && !ovf_hit) begin
      mem[0][eff_col] <= tdata_i;
      for (int i = 1; i < K - 1; i++) begin
        mem[i][eff_col] <= rd[i-1];
      end
    end
  end

  // Next-state logic for frame tracking, position counters, learned width and error flag.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    width_nxt = width;
    err_nxt   = err_o;
    if (take) begin
      state_nxt = ACTIVE;
      width_nxt = width_eff;
      row_nxt   = eff_row;
      if (tlast_i) begin
        col_nxt = '0;
        if (eff_row != RW'(K - 1)) row_nxt = eff_row + RW'(1);
        if (width_eff == '0) width_nxt = WW'(eff_col) + WW'(1);
        if (len_bad) err_nxt = 1'b1;
      end else if (ovf_hit) begin
        col_nxt = eff_col;
        err_nxt = 1'b1;
      end else begin
        col_nxt = eff_col + CW'(1);
      end
    end
  end

  // Frame-tracking state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      width <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      width <= width_nxt;
      err_o <= err_nxt;
    end
  end

  // Output register: load on a processed pixel, otherwise drain once downstream takes it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tvalid_o <= 1'b0;
      tdata_o  <= '0;
      tuser_o  <= 1'b0;
      tlast_o  <= 1'b0;
    end else if (take) begin
      tvalid_o <= 1'b1;
      tdata_o  <= col_vec;
      tuser_o  <= tuser_i;
      tlast_o  <= tlast_i;
    end else if (tready_i) begin
      tvalid_o <= 1'b0;
    end
  end

endmodule
